// File: rtl/alarm_pkg.sv
// Shared types and helpers for the alarm challenge checker.
//   state_e    : challenge FSM states
//   digit_t    : one 4-bit decimal digit / key code
//   fold_digit : map a 4-bit random value onto 0..9 (10..15 -> 4..9)
package alarm_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] digit_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_ENTRY   = 3'd2,
    ST_LOCKOUT = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Highest key code that is a real decimal digit; anything above never matches.
  localparam digit_t KEY_DIGIT_MAX = 4'd9;
  // Subtracting 6 folds 10..15 onto 4..9.
  localparam digit_t FOLD_OFFSET   = 4'd6;

  function automatic digit_t fold_digit(input digit_t d);
    return (d > KEY_DIGIT_MAX) ? digit_t'(d - FOLD_OFFSET) : d;
  endfunction

endpackage

// File: rtl/challenge_sequence_store.sv
// Register array holding the current challenge digits.
// Ports:
//   clk, rst_n : clock, async active-low reset (clears every slot)
//   i_we       : write enable (asserted while capturing)
//   i_waddr    : slot to write
//   i_wdata    : folded digit to store
//   i_raddr    : slot to read (the index the user must enter next)
//   o_rdata    : stored digit at i_raddr (combinational read)
module challenge_sequence_store
  import alarm_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int IDX_W      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  digit_t           i_wdata,
  input  logic [IDX_W-1:0] i_raddr,
  output digit_t           o_rdata
);

  digit_t r_mem [NUM_DIGITS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/alarm_challenge_checker.sv
// Alarm dismissal challenge: on alarm_trig, captures NUM_DIGITS folded random
// digits, shows them one at a time and checks keypad entry. A full correct
// entry dismisses the alarm; MAX_ATTEMPTS wrong entries cause a LOCK_CYCLES
// lockout followed by a fresh capture.
// Optional build macro: CHALLENGE_TIMEOUT_EN -- when defined, TIMEOUT_CYCLES
// of keypad inactivity in ENTRY return the entry index to 0 (no error, no
// attempt charged).
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   alarm_trig    : 1-cycle alarm pulse (acted on only in IDLE)
//   rnd_digit     : random source, sampled each CAPTURE cycle
//   key_valid     : 1-cycle key strobe (acted on only in ENTRY)
//   key_code      : key value
//   alarm_on      : high from trigger until dismissal
//   show_digit    : stored digit at show_idx while in ENTRY, else 0
//   show_idx      : index of the digit expected next
//   entry_active  : high in ENTRY
//   error_pulse   : 1 cycle after a wrong key
//   dismissed     : 1 cycle after the final correct key
//   locked        : high in LOCKOUT
//   dbg_state     : current FSM state for observation
// Key handshake: a key is consumed in the cycle key_valid is high while in
// ENTRY; there is no back-pressure and every response is registered, so it
// becomes visible exactly one cycle after the consumed strobe.
module alarm_challenge_checker
  import alarm_pkg::*;
#(
  parameter  int NUM_DIGITS     = 4,
  parameter  int MAX_ATTEMPTS   = 3,
  parameter  int LOCK_CYCLES    = 1000,
  parameter  int TIMEOUT_CYCLES = 5000,
  localparam int IDX_W          = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alarm_trig,
  input  logic [3:0]       rnd_digit,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic             alarm_on,
  output logic [3:0]       show_digit,
  output logic [IDX_W-1:0] show_idx,
  output logic             entry_active,
  output logic             error_pulse,
  output logic             dismissed,
  output logic             locked,
  output state_e           dbg_state
);

  localparam int LCW = $clog2(LOCK_CYCLES + 1);

  state_e           r_state;
  state_e           w_next_state;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_cap_idx;
  logic [3:0]       r_attempts;
  logic [LCW-1:0]   r_lock_cnt;
  logic             r_alarm_on;
  logic             r_error;
  logic             r_dismissed;

  digit_t           w_rd_digit;
  logic             w_key_accept;
  logic             w_key_match;
  logic             w_last_idx;
  logic             w_cap_last;
  logic             w_lock_done;
  logic [3:0]       w_attempts_inc;
  logic             w_timeout;

  challenge_sequence_store #(
    .NUM_DIGITS (NUM_DIGITS),
    .IDX_W      (IDX_W)
  ) u_store (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (r_state == ST_CAPTURE),
    .i_waddr (r_cap_idx),
    .i_wdata (fold_digit(rnd_digit)),
    .i_raddr (r_idx),
    .o_rdata (w_rd_digit)
  );

  assign w_key_accept   = (r_state == ST_ENTRY) && key_valid;
  // Stored digits are always 0..9, but the explicit range test keeps codes
  // 10..15 from ever counting as a match.
  assign w_key_match    = w_key_accept && (key_code <= KEY_DIGIT_MAX) &&
                          (key_code == w_rd_digit);
  assign w_last_idx     = (r_idx == IDX_W'(NUM_DIGITS - 1));
  assign w_cap_last     = (r_cap_idx == IDX_W'(NUM_DIGITS - 1));
  assign w_lock_done    = (r_lock_cnt == LCW'(LOCK_CYCLES - 1));
  assign w_attempts_inc = r_attempts + 4'd1;

`ifdef CHALLENGE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_to_cnt;

  // Fires only with a partial entry in progress; an idle index 0 never times out.
  assign w_timeout = (r_state == ST_ENTRY) && !key_valid && (r_idx != '0) &&
                     (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if ((r_state != ST_ENTRY) || key_valid || w_timeout) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != TO_W'(TIMEOUT_CYCLES - 1)) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:    if (alarm_trig) w_next_state = ST_CAPTURE;
      ST_CAPTURE: if (w_cap_last) w_next_state = ST_ENTRY;
      ST_ENTRY: begin
        if (w_key_accept) begin
          if (w_key_match) begin
            if (w_last_idx) w_next_state = ST_DONE;
          end else if (w_attempts_inc == 4'(MAX_ATTEMPTS)) begin
            w_next_state = ST_LOCKOUT;
          end
        end
      end
      ST_LOCKOUT: if (w_lock_done) w_next_state = ST_CAPTURE;
      ST_DONE:    w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_cap_idx   <= '0;
      r_attempts  <= '0;
      r_lock_cnt  <= '0;
      r_alarm_on  <= 1'b0;
      r_error     <= 1'b0;
      r_dismissed <= 1'b0;
    end else begin
      r_error     <= 1'b0;
      r_dismissed <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (alarm_trig) begin
            r_alarm_on <= 1'b1;
            r_attempts <= '0;
            r_idx      <= '0;
            r_cap_idx  <= '0;
          end
        end
        ST_CAPTURE: begin
          r_cap_idx <= w_cap_last ? '0 : r_cap_idx + IDX_W'(1);
          r_idx     <= '0;
        end
        ST_ENTRY: begin
          if (w_key_accept) begin
            if (w_key_match) begin
              if (w_last_idx) begin
                r_dismissed <= 1'b1;
                r_alarm_on  <= 1'b0;
                r_idx       <= '0;
              end else begin
                r_idx <= r_idx + IDX_W'(1);
              end
            end else begin
              r_error    <= 1'b1;
              r_idx      <= '0;
              r_attempts <= w_attempts_inc;
              r_lock_cnt <= '0;
            end
          end else if (w_timeout) begin
            r_idx <= '0;
          end
        end
        ST_LOCKOUT: begin
          if (w_lock_done) begin
            r_lock_cnt <= '0;
            r_attempts <= '0;
            r_cap_idx  <= '0;
          end else begin
            r_lock_cnt <= r_lock_cnt + LCW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign alarm_on     = r_alarm_on;
  assign entry_active = (r_state == ST_ENTRY);
  assign locked       = (r_state == ST_LOCKOUT);
  assign error_pulse  = r_error;
  assign dismissed    = r_dismissed;
  assign show_idx     = r_idx;
  assign show_digit   = (r_state == ST_ENTRY) ? w_rd_digit : 4'd0;
  assign dbg_state    = r_state;

endmodule
